// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer.
// Walks the 16 rounds from one PC-1 value (C0||D0), rotating the C and D halves
// by the fixed shift schedule. Each round it offers PC-2(CD) on a valid/ready
// port. Decrypt runs the schedule backwards with right rotations. CD16 == CD0,
// so decrypt starts directly from the loaded value and no key storage is needed.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; outputs quiet
//   ST_ROUND | offering the round key for round_q, held until rk_ready
//   ST_DONE  | one-cycle done pulse after the 16th handshake
module des_key_sched_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] cd_in,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [47:0] round_key,
    output logic [3:0]  rk_round,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // PC-2 selection table, first entry drives round_key[47].
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q;
    logic [55:0] cd_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic        busy_q;
    logic        rk_valid_q;
    logic        done_q;

    logic [55:0] cd_load_d;
    logic [55:0] cd_step_d;

    // Shift amount s[k] for k = 1..16; rounds 1, 2, 9 and 16 shift by one.
    function automatic logic [1:0] shift_amt(input logic [4:0] k);
        return (k == 5'd1 || k == 5'd2 || k == 5'd9 || k == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // C and D halves rotate independently.
    function automatic logic [55:0] rotl56(input logic [55:0] x, input logic [1:0] n);
        return {rotl28(x[55:28], n), rotl28(x[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr56(input logic [55:0] x, input logic [1:0] n);
        return {rotr28(x[55:28], n), rotr28(x[27:0], n)};
    endfunction

    // Next CD values: on accept (encrypt pre-rotates to CD1) and on each handshake.
    always_comb begin
        cd_load_d = decrypt ? cd_in : rotl56(cd_in, shift_amt(5'd1));
        cd_step_d = mode_q ? rotr56(cd_q, shift_amt(5'd16 - {1'b0, round_q}))
                           : rotl56(cd_q, shift_amt({1'b0, round_q} + 5'd2));
    end

    // Sequencer FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cd_q       <= '0;
            round_q    <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= decrypt;
                        cd_q       <= cd_load_d;
                        round_q    <= '0;
                        busy_q     <= 1'b1;
                        rk_valid_q <= 1'b1;
                        state_q    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (rk_ready) begin
                        if (round_q == 4'd15) begin
                            rk_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            cd_q    <= cd_step_d;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q     <= 1'b0;
                    rk_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // PC-2 decode straight from the registered CD, so the key is stable while held.
    always_comb begin
        round_key = '0;
        for (int i = 0; i < 48; i++) begin
            round_key[47 - i] = cd_q[6'(56 - PC2_TAB[i])];
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl using the classic DES example key
// (C0 = F0CCAAF, D0 = 556678F) and its published round keys K1..K16.
// Inputs are driven and outputs sampled on the falling edge.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] cd_in;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [47:0] round_key;
    logic [3:0]  rk_round;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [55:0] CD_REF = 56'hF0CCAAF556678F;

    logic [47:0] enc_keys [16];

    des_key_sched_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .decrypt   (decrypt),
        .cd_in     (cd_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_round  (rk_round),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start for one accept edge; afterwards scramble cd_in/decrypt (don't-care).
    task automatic do_start(input logic [55:0] cd, input logic dec);
        start   = 1'b1;
        cd_in   = cd;
        decrypt = dec;
        @(negedge clk);
        start   = 1'b0;
        cd_in   = ~cd;
        decrypt = ~dec;
    endtask

    // Full schedule with rk_ready high; checks every key, done timing and final state.
    task automatic run_ready_high(input logic [55:0] cd, input logic dec, input logic use_table,
                                  input logic [47:0] const_key, input string name);
        logic [47:0] exp_key;
        rk_ready = 1'b1;
        do_start(cd, dec);
        for (int k = 0; k < 16; k++) begin
            if (use_table)
                exp_key = dec ? enc_keys[15 - k] : enc_keys[k];
            else
                exp_key = const_key;
            vectors++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(k) || round_key !== exp_key ||
                busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s key%0d: valid=%b round=%0d key=%h busy=%b done=%b, want valid=1 round=%0d key=%h busy=1 done=0",
                         name, k, rk_valid, rk_round, round_key, busy, done, k, exp_key);
            end
            @(negedge clk);
        end
        // 17th cycle after the accept edge: done pulse
        vectors++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_cycle: done=%b valid=%b busy=%b, want done=1 valid=0 busy=1",
                     name, done, rk_valid, busy);
        end
        if (!dec) begin
            vectors++;
            if (dut.cd_q !== cd) begin
                miscompares++;
                $display("FAIL %s cd_return: cd=%h want %h", name, dut.cd_q, cd);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b, want all 0",
                     name, done, busy, rk_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; decrypt = 1'b0; cd_in = CD_REF; rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 ||
            rk_round !== 4'd0 || round_key !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b valid=%b done=%b round=%0d key=%h, want 0s",
                     busy, rk_valid, done, rk_round, round_key);
        end
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: busy=%b valid=%b, want 0 0", busy, rk_valid);
        end
    endtask

    task automatic test_encrypt;
        run_ready_high(CD_REF, 1'b0, 1'b1, 48'h0, "encrypt");
    endtask

    task automatic test_decrypt;
        run_ready_high(CD_REF, 1'b1, 1'b1, 48'h0, "decrypt");
    endtask

    task automatic test_backpressure;
        int          hs;
        int          cyc;
        int          dones;
        logic        hold;
        logic        rdy;
        logic [47:0] pkey;
        logic [3:0]  pround;
        hs = 0; cyc = 0; dones = 0; hold = 1'b0; pkey = '0; pround = '0;
        rk_ready = 1'b0;
        do_start(CD_REF, 1'b0);
        while (cyc < 400) begin
            if (done) begin
                dones++;
                break;
            end
            if (hold) begin
                vectors++;
                if (rk_valid !== 1'b1 || round_key !== pkey || rk_round !== pround) begin
                    miscompares++;
                    $display("FAIL bp_stall_stable: valid=%b round=%0d key=%h, want valid=1 round=%0d key=%h",
                             rk_valid, rk_round, round_key, pround, pkey);
                end
                hold = 1'b0;
            end
            if (rk_valid) begin
                vectors++;
                if (hs > 15 || rk_round !== 4'(hs) || round_key !== enc_keys[hs[3:0]]) begin
                    miscompares++;
                    $display("FAIL bp_key%0d: round=%0d key=%h, want round=%0d key=%h",
                             hs, rk_round, round_key, hs, enc_keys[hs[3:0]]);
                end
                rdy = ($urandom_range(0, 99) < 40);
                rk_ready = rdy;
                if (rdy) begin
                    hs++;
                end else begin
                    hold   = 1'b1;
                    pkey   = round_key;
                    pround = rk_round;
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (dones != 1 || hs != 16) begin
            miscompares++;
            $display("FAIL bp_count: handshakes=%0d done_pulses=%0d, want 16 1", hs, dones);
        end
        rk_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_single_done: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_start_ignored;
        int cyc;
        rk_ready = 1'b1;
        do_start(CD_REF, 1'b0);
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(k) || round_key !== enc_keys[k]) begin
                miscompares++;
                $display("FAIL ign_key%0d: valid=%b round=%0d key=%h, want valid=1 round=%0d key=%h",
                         k, rk_valid, rk_round, round_key, k, enc_keys[k]);
            end
            start   = (k == 3 || k == 10);
            cd_in   = 56'h0123456789ABCD;
            decrypt = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_done: done=%b want 1", done);
        end
        start = 1'b1; cd_in = 56'h0123456789ABCD; decrypt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_start_in_done: busy=%b valid=%b done=%b, want 0 0 0",
                     busy, rk_valid, done);
        end
        do_start(CD_REF, 1'b1);
        vectors++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || round_key !== enc_keys[15]) begin
            miscompares++;
            $display("FAIL ign_restart: valid=%b round=%0d key=%h, want valid=1 round=0 key=%h",
                     rk_valid, rk_round, round_key, enc_keys[15]);
        end
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_drain: done=%b want 1 within 40 cycles", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bad;
        rk_ready = 1'b1;
        do_start(CD_REF, 1'b0);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (rk_round !== 4'(k) || round_key !== enc_keys[k]) begin
                miscompares++;
                $display("FAIL rmid_key%0d: round=%0d key=%h, want round=%0d key=%h",
                         k, rk_round, round_key, k, enc_keys[k]);
            end
            if (k < 7) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || round_key !== 48'h0 ||
            done !== 1'b0 || rk_round !== 4'd0) begin
            miscompares++;
            $display("FAIL rmid_abort: busy=%b valid=%b key=%h done=%b round=%0d, want 0s",
                     busy, rk_valid, round_key, done, rk_round);
        end
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rmid_no_done: %0d cycles with done/busy high, want 0", bad);
        end
        run_ready_high(CD_REF, 1'b0, 1'b1, 48'h0, "rmid_restart");
    endtask

    task automatic test_constants;
        run_ready_high(56'h0,    1'b0, 1'b0, 48'h0,            "zero_enc");
        run_ready_high(56'h0,    1'b1, 1'b0, 48'h0,            "zero_dec");
        run_ready_high({56{1'b1}}, 1'b0, 1'b0, 48'hFFFFFFFFFFFF, "ones_enc");
        run_ready_high({56{1'b1}}, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, "ones_dec");
    endtask

    initial begin
        enc_keys[0]  = 48'b000110_110000_001011_101111_111111_000111_000001_110010;
        enc_keys[1]  = 48'b011110_011010_111011_011001_110110_111100_100111_100101;
        enc_keys[2]  = 48'b010101_011111_110010_001010_010000_101100_111110_011001;
        enc_keys[3]  = 48'b011100_101010_110111_010110_110110_110011_010100_011101;
        enc_keys[4]  = 48'b011111_001110_110000_000111_111010_110101_001110_101000;
        enc_keys[5]  = 48'b011000_111010_010100_111110_010100_000111_101100_101111;
        enc_keys[6]  = 48'b111011_001000_010010_110111_111101_100001_100010_111100;
        enc_keys[7]  = 48'b111101_111000_101000_111010_110000_010011_101111_111011;
        enc_keys[8]  = 48'b111000_001101_101111_101011_111011_011110_011110_000001;
        enc_keys[9]  = 48'b101100_011111_001101_000111_101110_100100_011001_001111;
        enc_keys[10] = 48'b001000_010101_111111_010011_110111_101101_001110_000110;
        enc_keys[11] = 48'b011101_010111_000111_110101_100101_000110_011111_101001;
        enc_keys[12] = 48'b100101_111100_010111_010001_111110_101011_101001_000001;
        enc_keys[13] = 48'b010111_110100_001110_110111_111100_101110_011100_111010;
        enc_keys[14] = 48'b101111_111001_000110_001101_001111_010011_111100_001010;
        enc_keys[15] = 48'b110010_110011_110110_001011_000011_100001_011111_110101;

        rst = 1'b0; start = 1'b0; decrypt = 1'b0; cd_in = '0; rk_ready = 1'b0;

        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_start_ignored;
        test_reset_mid;
        test_constants;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
Sequences the DES key schedule for one 56-bit PC-1 key. It takes the 56-bit C0||D0 value from the PC-1 stage and walks the 16 rounds, rotating the C and D halves per the FIPS 46-3 shift schedule. Each round it applies PC-2 and hands one 48-bit round key to the round datapath through a valid/ready handshake. Encrypt mode issues K1..K16; decrypt mode issues K16..K1 using right rotations, so no key storage is needed.

Parameters:
- none; round count (16) and shift schedule (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) are fixed constants.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request a new schedule; sampled only in IDLE
- decrypt  in  1  0 = K1..K16, 1 = K16..K1; captured with start
- cd_in  in  56  PC-1 output; [55:28] = C0, [27:0] = D0; captured with start
- busy  out  1  high from the cycle after start is accepted until done
- rk_valid  out  1  round_key/rk_round valid
- rk_ready  in  1  consumer accepts the current key
- round_key  out  48  PC-2 of the current CD register
- rk_round  out  4  index of the key offered (0..15), in issue order
- done  out  1  one-cycle pulse after the 16th handshake

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst). When rst == 0 at a rising edge:
  - state = IDLE; cd = 0; round = 0.
  - busy = 0, rk_valid = 0, done = 0, rk_round = 0, round_key = 0.
- Rotations act on C (cd[55:28]) and D (cd[27:0]) independently, each 28-bit circular. rotl/rotr by 1 or 2 only.
- PC-2 uses the FIPS 46-3 table. Table entry n (1..56) selects cd[56-n]. The first table entry drives round_key[47].
- round_key = PC2(cd), decoded from the registered cd. It is stable while rk_valid is high.
- s[k], k = 1..16, denotes the shift schedule.
- State IDLE:
  - busy = 0, rk_valid = 0.
  - If start == 1: capture decrypt into mode; cd <= mode ? cd_in : rotl(cd_in, s[1]); round <= 0; next state ROUND.
  - CD16 equals CD0, so decrypt's first key is PC2(cd_in).
- State ROUND:
  - busy = 1, rk_valid = 1, rk_round = round.
  - No change while rk_ready == 0 (hold all outputs).
  - Handshake occurs when rk_valid && rk_ready.
  - On handshake with round < 15:
    - round <= round + 1.
    - Encrypt: cd <= rotl(cd, s[round+2]).
    - Decrypt: cd <= rotr(cd, s[16-round]).
  - On handshake with round == 15: next state DONE; rk_valid drops the following cycle.
- State DONE:
  - done = 1 and busy = 1 for exactly one cycle, then IDLE.
  - start is ignored in DONE. The earliest new accept is the cycle after done.
- start while busy: ignored, no side effects. cd_in and decrypt are don't-care outside the accept cycle.
- Latency:
  - First key valid 1 cycle after the start accept edge.
  - With rk_ready tied high: one key per cycle, 16 cycles, done on the 17th cycle after accept.
- Reset mid-operation: abort immediately to the reset values. No partial done pulse. Next start behaves normally.
- Total rotation over 16 rounds = 28, so cd returns to CD0 after K16 (encrypt). The bench checks this.

Test Plan:
- Encrypt, rk_ready = 1, cd_in = 56'hF0CCAAF556678F, decrypt = 0 -> rk_round 0 key 48'h1B02EFFC7072, rk_round 1 key 48'h79AED9DBC9E5, rk_round 15 key 48'hCB3D8B0E17F5; done 17 cycles after accept; cd back to cd_in.
- Decrypt, same cd_in -> rk_round 0 key 48'hCB3D8B0E17F5, rk_round 14 key 48'h79AED9DBC9E5, rk_round 15 key 48'h1B02EFFC7072; all 16 keys are the exact reverse of the encrypt run.
- Backpressure: random rk_ready (~40% high) -> key sequence identical to the first scenario; round_key/rk_round stable whenever rk_valid && !rk_ready; exactly 16 handshakes; one done pulse.
- start pulsed with a different cd_in during ROUND and DONE -> ignored; sequence completes unchanged; a start in the cycle after done is accepted.
- rst low at rk_round 7 -> next cycle busy = 0, rk_valid = 0, round_key = 0, no done; a fresh start reproduces the first scenario from K1.
- cd_in = 0 and cd_in = all-ones, both modes -> all keys 48'h0 and 48'hFFFFFFFFFFFF respectively (rotation/PC-2 coverage sanity).
